wait_event_initiator: RTL and testbench
=======================================

Name: wait_event_initiator

Overview:
Command-side counterpart of the testbench wait-event responder.
- Accepts WAIT commands on a valid/ready interface and issues them to the responder as a one-cycle select/args strobe.
- Supervises the wait with a per-command timeout, then returns a status/latency response.
- Sits between the scenario command decoder and the wait-event responder. Strings are replaced by indices: alias index, mode code, expected value.

Parameters:
WAIT_SIZE, 5, number of waitable signals (alias slots)
WAIT_WIDTH, 1, width of each waitable signal / expected value
TIMEOUT_WIDTH, 32, width of timeout and elapsed-cycle counters
IDX_W, $clog2(WAIT_SIZE), alias index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  initiator can accept command
i_cmd_idx  in  IDX_W  alias index to wait on
i_cmd_mode  in  2  0=RISE, 1=FALL, 2=VALUE, 3=reserved
i_cmd_value  in  WAIT_WIDTH  expected value (VALUE mode)
i_cmd_timeout  in  TIMEOUT_WIDTH  max wait cycles; 0 = no timeout
o_sel_wait  out  1  wait block selected (high ISSUE..WAIT)
o_args_valid  out  1  one-cycle args strobe
o_args_idx  out  IDX_W  latched alias index
o_args_mode  out  2  latched mode
o_args_value  out  WAIT_WIDTH  latched expected value
i_wait_done  in  1  responder completion pulse
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed
o_rsp_status  out  2  0=DONE, 1=TIMEOUT, 2=BAD_CMD
o_rsp_cycles  out  TIMEOUT_WIDTH  cycles spent in WAIT (saturating)
o_busy  out  1  FSM not IDLE
o_timeout_cnt  out  16  total timeouts since reset (saturating)

Behaviour:
- Reset, sampled on posedge clk: FSM=IDLE, all outputs 0 except o_cmd_ready=1. Args, counters and o_timeout_cnt cleared.
- Reset mid-operation aborts the wait with no response, and o_sel_wait drops the next cycle.
- Command acceptance: accepted on posedge when i_cmd_valid && o_cmd_ready. o_cmd_ready=1 only in IDLE.
- On acceptance, idx/mode/value/timeout are latched into args registers, which remain stable until the next acceptance.
- Validation: accepted command with i_cmd_idx >= WAIT_SIZE or mode==3 goes IDLE->RESP with status BAD_CMD, cycles=0. No strobe is issued.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: valid command -> ISSUE.
  - ISSUE (exactly 1 cycle): o_sel_wait=1, o_args_valid=1. Cycle counter cleared. -> WAIT.
  - WAIT: o_sel_wait=1, o_args_valid=0. Cycle counter increments each cycle, saturating at all-ones.
    - i_wait_done=1 -> RESP with DONE.
    - Timeout != 0 and counter+1 == timeout -> RESP with TIMEOUT; o_timeout_cnt increments, saturating at 16'hFFFF.
    - Done and timeout in the same cycle: DONE wins.
  - RESP: o_sel_wait=0, o_rsp_valid=1. Status and cycles held stable until i_rsp_ready. On the handshake -> IDLE, o_cmd_ready rises the following cycle.
- Latency: command accept at edge N -> o_args_valid high during cycle N+1 -> WAIT from N+2.
- Done sampled at edge N+2+k gives rsp_cycles = k+1 and o_rsp_valid high from cycle N+3+k.
- Timeout T: TIMEOUT response with rsp_cycles=T.
- i_wait_done is ignored in IDLE, ISSUE and RESP. A done during ISSUE is stale and not honoured.
- No command queueing: a back-to-back command waits in IDLE. The minimum command-to-command period is 4 cycles.

Decomposition:
- Package wait_event_pkg holds:
  - typedef enum logic [1:0] wait_mode_t {RISE, FALL, VALUE, RSVD};
  - typedef enum logic [1:0] wait_status_t {ST_DONE, ST_TIMEOUT, ST_BAD_CMD};
  - typedef enum logic [1:0] fsm_t {IDLE, ISSUE, WAIT, RESP}.
- The responder imports the same package.
- One sub-module, wait_timeout_cnt: holds the clear/enable/saturating counter and the compare against the latched timeout. It outputs count and expired.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-WAIT -> o_sel_wait=0, o_rsp_valid=0, o_cmd_ready=1, o_timeout_cnt=0; no response emitted.
- Normal wait: cmd idx=2, mode=RISE, timeout=100; done pulse 7 cycles after o_args_valid -> one-cycle o_args_valid with idx=2, rsp status=DONE, cycles=7.
- Timeout: idx=1, mode=VALUE, value=1, timeout=10, no done -> TIMEOUT, cycles=10, o_timeout_cnt=1. A second identical command gives o_timeout_cnt=2.
- Tie and stale done:
  - done asserted in the cycle the counter reaches timeout=5 -> DONE, cycles=5.
  - done asserted during ISSUE -> ignored; a later done at k=3 gives cycles=4.
- Bad command: idx=5 (WAIT_SIZE=5), then mode=3 -> BAD_CMD, cycles=0, o_args_valid never asserted.
- Response backpressure: i_rsp_ready=0 for 6 cycles -> o_rsp_valid/status/cycles stable and o_cmd_ready=0 throughout. Accept on ready, and a pending i_cmd_valid is taken one cycle later.

Source files
------------

// File: rtl/wait_event_pkg.sv
// rtl/wait_event_pkg.sv - shared types for the wait-event initiator and responder
//
// Holds the command mode, response status and FSM state encodings used by
// both sides of the wait-event link.

package wait_event_pkg;

    typedef enum logic [1:0] {
        RISE  = 2'd0,
        FALL  = 2'd1,
        VALUE = 2'd2,
        RSVD  = 2'd3
    } wait_mode_t;

    typedef enum logic [1:0] {
        ST_DONE    = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_BAD_CMD = 2'd2
    } wait_status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fsm_t;

endpackage

// File: rtl/wait_timeout_cnt.sv
// rtl/wait_timeout_cnt.sv - saturating elapsed-cycle counter with timeout compare
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   clr         zero the count (takes priority over en)
//   en          count one cycle
//   timeout     latched timeout; 0 disables expiry
//   count       cycles counted so far, saturating at all-ones
//   expired     this counting cycle is the last one allowed by timeout

module wait_timeout_cnt #(
    parameter int TIMEOUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    output logic [TIMEOUT_WIDTH-1:0] count,
    output logic                     expired
);

    // One extra bit so a saturated count can never alias onto a timeout value.
    logic [TIMEOUT_WIDTH:0] count_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    assign count_inc = {1'b0, count} + (TIMEOUT_WIDTH + 1)'(1);
    assign expired   = en && (timeout != '0) && (count_inc == {1'b0, timeout});

endmodule

// File: rtl/wait_event_initiator.sv
// rtl/wait_event_initiator.sv - issues WAIT commands to the responder and supervises them
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready          command handshake (ready only when idle)
//   i_cmd_idx/mode/value/timeout     command fields
//   o_sel_wait                       responder selected (ISSUE and WAIT)
//   o_args_valid, o_args_idx/mode/value  one-cycle strobe plus latched args
//   i_wait_done                      responder completion pulse (WAIT only)
//   o_rsp_valid/i_rsp_ready          response handshake
//   o_rsp_status, o_rsp_cycles       outcome and cycles spent in WAIT
//   o_busy                           not idle
//   o_timeout_cnt                    saturating count of timeouts since reset

module wait_event_initiator
    import wait_event_pkg::*;
#(
    parameter  int WAIT_SIZE     = 5,
    parameter  int WAIT_WIDTH    = 1,
    parameter  int TIMEOUT_WIDTH = 32,
    localparam int IDX_W         = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [IDX_W-1:0]         i_cmd_idx,
    input  logic [1:0]               i_cmd_mode,
    input  logic [WAIT_WIDTH-1:0]    i_cmd_value,
    input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
    output logic                     o_sel_wait,
    output logic                     o_args_valid,
    output logic [IDX_W-1:0]         o_args_idx,
    output logic [1:0]               o_args_mode,
    output logic [WAIT_WIDTH-1:0]    o_args_value,
    input  logic                     i_wait_done,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [TIMEOUT_WIDTH-1:0] o_rsp_cycles,
    output logic                     o_busy,
    output logic [15:0]              o_timeout_cnt
);

    localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W + 1)'(WAIT_SIZE);

    fsm_t                     state, next_state;
    wait_status_t             rsp_status;
    logic [TIMEOUT_WIDTH-1:0] args_timeout;
    logic [TIMEOUT_WIDTH-1:0] tmo_count;
    logic [TIMEOUT_WIDTH-1:0] cycles_next;
    logic                     tmo_expired;
    logic                     cmd_accept;
    logic                     cmd_bad;

    assign cmd_accept = i_cmd_valid && (state == IDLE);
    assign cmd_bad    = ({1'b0, i_cmd_idx} >= IDX_LIMIT) || (wait_mode_t'(i_cmd_mode) == RSVD);

    // The reported figure includes the terminating WAIT cycle itself.
    assign cycles_next = (&tmo_count) ? tmo_count : tmo_count + TIMEOUT_WIDTH'(1);

    wait_timeout_cnt #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == ISSUE),
        .en     (state == WAIT),
        .timeout(args_timeout),
        .count  (tmo_count),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        o_cmd_ready  = 1'b0;
        o_sel_wait   = 1'b0;
        o_args_valid = 1'b0;
        o_rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    next_state = cmd_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                o_sel_wait   = 1'b1;
                o_args_valid = 1'b1;
                next_state   = WAIT;
            end
            WAIT: begin
                o_sel_wait = 1'b1;
                if (i_wait_done || tmo_expired) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_args_idx    <= '0;
            o_args_mode   <= '0;
            o_args_value  <= '0;
            args_timeout  <= '0;
            rsp_status    <= ST_DONE;
            o_rsp_cycles  <= '0;
            o_timeout_cnt <= '0;
        end else begin
            if (cmd_accept) begin
                o_args_idx   <= i_cmd_idx;
                o_args_mode  <= i_cmd_mode;
                o_args_value <= i_cmd_value;
                args_timeout <= i_cmd_timeout;
                if (cmd_bad) begin
                    rsp_status   <= ST_BAD_CMD;
                    o_rsp_cycles <= '0;
                end
            end
            if (state == WAIT) begin
                // A done in the expiry cycle wins over the timeout.
                if (i_wait_done) begin
                    rsp_status   <= ST_DONE;
                    o_rsp_cycles <= cycles_next;
                end else if (tmo_expired) begin
                    rsp_status   <= ST_TIMEOUT;
                    o_rsp_cycles <= cycles_next;
                    if (o_timeout_cnt != 16'hFFFF) begin
                        o_timeout_cnt <= o_timeout_cnt + 16'd1;
                    end
                end
            end
        end
    end

    assign o_rsp_status = rsp_status;
    assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_wait_event_initiator.sv
// tb/tb_wait_event_initiator.sv - randomized timeline-model bench for wait_event_initiator

module tb_wait_event_initiator;
    import wait_event_pkg::*;

    localparam int WS   = 5;
    localparam int WW   = 1;
    localparam int TW   = 32;
    localparam int IW   = 3;
    localparam int MAXP = 12000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_cmd_valid, o_cmd_ready;
    logic [IW-1:0] i_cmd_idx;
    logic [1:0]    i_cmd_mode;
    logic [WW-1:0] i_cmd_value;
    logic [TW-1:0] i_cmd_timeout;
    logic          o_sel_wait, o_args_valid;
    logic [IW-1:0] o_args_idx;
    logic [1:0]    o_args_mode;
    logic [WW-1:0] o_args_value;
    logic          i_wait_done, o_rsp_valid, i_rsp_ready;
    logic [1:0]    o_rsp_status;
    logic [TW-1:0] o_rsp_cycles;
    logic          o_busy;
    logic [15:0]   o_timeout_cnt;

    wait_event_initiator #(.WAIT_SIZE(WS), .WAIT_WIDTH(WW), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_idx(i_cmd_idx), .i_cmd_mode(i_cmd_mode),
        .i_cmd_value(i_cmd_value), .i_cmd_timeout(i_cmd_timeout),
        .o_sel_wait(o_sel_wait), .o_args_valid(o_args_valid),
        .o_args_idx(o_args_idx), .o_args_mode(o_args_mode), .o_args_value(o_args_value),
        .i_wait_done(i_wait_done), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_status(o_rsp_status), .o_rsp_cycles(o_rsp_cycles),
        .o_busy(o_busy), .o_timeout_cnt(o_timeout_cnt)
    );

    always #5 clk = ~clk;

    // Input schedule, one entry per clock period (period p follows edge p).
    logic          in_rst   [MAXP];
    logic          in_valid [MAXP];
    logic [IW-1:0] in_idx   [MAXP];
    logic [1:0]    in_mode  [MAXP];
    logic [WW-1:0] in_value [MAXP];
    logic [TW-1:0] in_tmo   [MAXP];
    logic          in_done  [MAXP];
    logic          in_ready [MAXP];

    // Expected outputs per period.
    logic          e_ready [MAXP], e_sel [MAXP], e_av [MAXP], e_rv [MAXP], e_busy [MAXP];
    logic [15:0]   e_tcnt  [MAXP];
    logic          e_args_on [MAXP];
    logic [IW-1:0] e_idx   [MAXP];
    logic [1:0]    e_mode  [MAXP];
    logic [WW-1:0] e_value [MAXP];
    logic [1:0]    e_status [MAXP];
    logic [TW-1:0] e_cycles [MAXP];

    // Hand-computed literals for the directed commands.
    logic          lit_rsp_on [MAXP];
    logic [1:0]    lit_status [MAXP];
    logic [TW-1:0] lit_cycles [MAXP];
    logic          lit_tcnt_on [MAXP];
    logic [15:0]   lit_tcnt [MAXP];

    int          cur, prev_a, last_s, end_p;
    logic [15:0] m_tcnt;
    int          n_cmp, n_bad;

    task automatic set_idle(input int p);
        e_ready[p] = 1'b1; e_sel[p] = 1'b0; e_av[p] = 1'b0; e_rv[p] = 1'b0;
        e_busy[p] = 1'b0; e_args_on[p] = 1'b0; e_tcnt[p] = m_tcnt;
    endtask

    task automatic set_busy(input int p, input logic sel, input logic av, input logic rv);
        e_ready[p] = 1'b0; e_sel[p] = sel; e_av[p] = av; e_rv[p] = rv;
        e_busy[p] = 1'b1; e_args_on[p] = sel; e_tcnt[p] = m_tcnt;
    endtask

    task automatic set_args(input int p, input int idx, input int mode, input int value);
        e_idx[p] = IW'(idx); e_mode[p] = 2'(mode); e_value[p] = WW'(value);
    endtask

    // Plans one command: outcome from the wait rules, then its whole timeline.
    task automatic plan_cmd(input int idx, input int mode, input int value, input int tmo,
                            input int done_at, input bit stale, input int d, input int pend);
        int v, a, s, h, ncyc;
        bit good;
        logic [1:0] st;
        v = cur - pend;
        if (v < prev_a + 1) v = prev_a + 1;
        a = ((v > cur) ? v : cur) + 1;
        for (int p = cur; p < a; p++) set_idle(p);
        for (int p = v; p < a; p++) begin
            in_valid[p] = 1'b1; in_idx[p] = IW'(idx); in_mode[p] = 2'(mode);
            in_value[p] = WW'(value); in_tmo[p] = TW'(tmo);
        end
        good = (idx < WS) && (mode != 3);
        if (!good) begin
            st = ST_BAD_CMD; ncyc = 0; s = a;
        end else begin
            if (done_at != 0 && (tmo == 0 || done_at <= tmo)) begin
                st = ST_DONE; ncyc = done_at;
            end else begin
                st = ST_TIMEOUT; ncyc = tmo;
            end
            s = a + ncyc + 1;
            set_busy(a, 1'b1, 1'b1, 1'b0); set_args(a, idx, mode, value);
            in_done[a] = stale;
            for (int p = a + 1; p < s; p++) begin
                set_busy(p, 1'b1, 1'b0, 1'b0); set_args(p, idx, mode, value);
                in_done[p] = 1'b0;
            end
            if (st == ST_DONE) in_done[s-1] = 1'b1;
            if (st == ST_TIMEOUT && m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
        end
        h = s + d + 1;
        for (int p = s; p < h; p++) begin
            set_busy(p, 1'b0, 1'b0, 1'b1);
            e_status[p] = st; e_cycles[p] = TW'(ncyc);
            in_ready[p] = (p == h - 1);
        end
        prev_a = a; last_s = s; cur = h;
    endtask

    // Command with no timeout and no done, aborted by a 3-cycle reset mid-WAIT.
    task automatic plan_reset_mid_wait();
        int a;
        a = cur + 1;
        set_idle(cur);
        in_valid[cur] = 1'b1; in_idx[cur] = 3'd3; in_mode[cur] = 2'd1;
        in_value[cur] = 1'b0; in_tmo[cur] = '0;
        set_busy(a, 1'b1, 1'b1, 1'b0); set_args(a, 3, 1, 0);
        in_done[a] = 1'b0;
        for (int p = a + 1; p <= a + 4; p++) begin
            set_busy(p, 1'b1, 1'b0, 1'b0); set_args(p, 3, 1, 0);
            in_done[p] = 1'b0;
        end
        for (int p = a + 4; p <= a + 6; p++) begin
            in_rst[p] = 1'b0; in_done[p] = 1'b0;
        end
        m_tcnt = 16'd0;
        for (int p = a + 5; p <= a + 7; p++) begin
            set_idle(p);
            lit_tcnt_on[p] = 1'b1; lit_tcnt[p] = 16'd0;
        end
        prev_a = a; cur = a + 7;
    endtask

    task automatic lit_rsp(input logic [1:0] st, input int cyc);
        lit_rsp_on[last_s] = 1'b1; lit_status[last_s] = st; lit_cycles[last_s] = TW'(cyc);
    endtask

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s period %0d: got %0h want %0h", nm, p, act, exp);
        end
    endtask

    task automatic check_period(input int p);
        chk("cmd_ready",   p, 32'(o_cmd_ready),   32'(e_ready[p]));
        chk("sel_wait",    p, 32'(o_sel_wait),    32'(e_sel[p]));
        chk("args_valid",  p, 32'(o_args_valid),  32'(e_av[p]));
        chk("rsp_valid",   p, 32'(o_rsp_valid),   32'(e_rv[p]));
        chk("busy",        p, 32'(o_busy),        32'(e_busy[p]));
        chk("timeout_cnt", p, 32'(o_timeout_cnt), 32'(e_tcnt[p]));
        if (e_args_on[p]) begin
            chk("args_idx",   p, 32'(o_args_idx),   32'(e_idx[p]));
            chk("args_mode",  p, 32'(o_args_mode),  32'(e_mode[p]));
            chk("args_value", p, 32'(o_args_value), 32'(e_value[p]));
        end
        if (e_rv[p]) begin
            chk("rsp_status", p, 32'(o_rsp_status), 32'(e_status[p]));
            chk("rsp_cycles", p, o_rsp_cycles,      e_cycles[p]);
        end
        if (lit_rsp_on[p]) begin
            chk("lit_status", p, 32'(o_rsp_status), 32'(lit_status[p]));
            chk("lit_cycles", p, o_rsp_cycles,      lit_cycles[p]);
        end
        if (lit_tcnt_on[p]) chk("lit_timeout_cnt", p, 32'(o_timeout_cnt), 32'(lit_tcnt[p]));
    endtask

    task automatic drive(input int p);
        rst_n         = in_rst[p];
        i_cmd_valid   = in_valid[p];
        i_cmd_idx     = in_idx[p];
        i_cmd_mode    = in_mode[p];
        i_cmd_value   = in_value[p];
        i_cmd_timeout = in_tmo[p];
        i_wait_done   = in_done[p];
        i_rsp_ready   = in_ready[p];
    endtask

    initial begin
        int idx, mode, value, tmo, done_at, d, pend;
        bit stale;
        n_cmp = 0; n_bad = 0; m_tcnt = 16'd0;
        for (int p = 0; p < MAXP; p++) begin
            in_rst[p] = 1'b1; in_valid[p] = 1'b0;
            in_idx[p] = IW'($urandom_range(0, 7)); in_mode[p] = 2'($urandom_range(0, 3));
            in_value[p] = WW'($urandom_range(0, 1)); in_tmo[p] = TW'($urandom_range(0, 20));
            in_done[p] = 1'($urandom_range(0, 1)); in_ready[p] = 1'($urandom_range(0, 1));
            set_idle(p);
            lit_rsp_on[p] = 1'b0; lit_tcnt_on[p] = 1'b0;
        end
        for (int p = 0; p < 3; p++) begin
            in_rst[p] = 1'b0; in_valid[p] = 1'b0;
        end
        cur = 3; prev_a = 2;

        plan_cmd(2, 0, 0, 100, 7, 1'b0, 0, 0); lit_rsp(ST_DONE, 7);
        plan_cmd(1, 2, 1, 10, 0, 1'b0, 0, 0);  lit_rsp(ST_TIMEOUT, 10);
        lit_tcnt_on[last_s] = 1'b1; lit_tcnt[last_s] = 16'd1;
        plan_cmd(1, 2, 1, 10, 0, 1'b0, 0, 0);  lit_rsp(ST_TIMEOUT, 10);
        lit_tcnt_on[last_s] = 1'b1; lit_tcnt[last_s] = 16'd2;
        plan_reset_mid_wait();
        plan_cmd(0, 1, 0, 5, 5, 1'b0, 0, 0);   lit_rsp(ST_DONE, 5);
        plan_cmd(4, 0, 0, 50, 4, 1'b1, 0, 0);  lit_rsp(ST_DONE, 4);
        plan_cmd(5, 0, 0, 9, 3, 1'b0, 0, 0);   lit_rsp(ST_BAD_CMD, 0);
        plan_cmd(1, 3, 0, 9, 3, 1'b0, 0, 0);   lit_rsp(ST_BAD_CMD, 0);
        plan_cmd(3, 2, 0, 20, 2, 1'b0, 6, 0);  lit_rsp(ST_DONE, 2);
        plan_cmd(2, 0, 1, 8, 1, 1'b0, 0, 3);   lit_rsp(ST_DONE, 1);

        while (cur < MAXP - 200) begin
            idx     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            mode    = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            value   = int'($urandom_range(0, 1));
            tmo     = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            done_at = int'($urandom_range(0, 14));
            if (tmo == 0 && done_at == 0) done_at = int'($urandom_range(1, 14));
            stale   = 1'($urandom_range(0, 1));
            d       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            pend    = int'($urandom_range(0, 3));
            plan_cmd(idx, mode, value, tmo, done_at, stale, d, pend);
        end
        end_p = cur + 6;
        for (int p = cur; p < end_p; p++) set_idle(p);

        fork
            begin
                for (int p = 0; p < end_p; p++) begin
                    drive(p);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int q = 1; q < end_p; q++) begin
                    @(negedge clk);
                    check_period(q);
                end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
